// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: opcodes, immediate
// formats, decode result and skid-buffer occupancy states.
package imm_gen_pkg;

    // Decode results are carried at the widest legal XLEN; consumers slice.
    localparam int IMM_MAX = 64;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        OP_IMM = 7'b0010011,
        AUIPC  = 7'b0010111,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        LUI    = 7'b0110111,
        BRANCH = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd7
    } imm_fmt_t;

    typedef struct packed {
        logic [IMM_MAX-1:0] imm;
        imm_fmt_t           fmt;
        logic               illegal;
    } imm_dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: classifies the instruction format and
// sign-extends the immediate to XLEN (bits above XLEN are left zero).
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output imm_dec_t    dec
);

    logic [31:0] imm32;

    always_comb begin
        imm32       = '0;
        dec         = '0;
        dec.fmt     = FMT_R;
        dec.illegal = 1'b0;
        case (opcode_t'(instr[6:0]))
            LOAD, OP_IMM, JALR: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                dec.fmt = FMT_I;
            end
            STORE: begin
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.fmt = FMT_S;
            end
            BRANCH: begin
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec.fmt = FMT_B;
            end
            LUI, AUIPC: begin
                imm32   = {instr[31:12], 12'h000};
                dec.fmt = FMT_U;
            end
            JAL: begin
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec.fmt = FMT_J;
            end
            OP: dec.fmt = FMT_R;
            default: begin
                dec.fmt     = FMT_BAD;
                dec.illegal = 1'b1;
            end
        endcase
        // Every 32-bit form already carries instr[31] in bit 31, so extending imm32 is enough.
        dec.imm[XLEN-1:0] = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeding a 2-entry skid buffer with
// valid/ready on both sides. Optional illegal-opcode counter: IMM_GEN_STATS_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [CNT_W-1:0] illegal_count
`endif
);

    imm_dec_t dec;
    imm_decode #(.XLEN(XLEN)) u_decode (.instr(in_instr), .dec(dec));

    // Bits of the decode result above XLEN are always zero.
    logic unused_dec_imm;
    assign unused_dec_imm = ^dec.imm;

    occ_t             state, state_nxt;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;
    logic             in_xfer, out_xfer, load_out, load_skid, pop_skid;

    // Both handshake outputs decode the state flop only, so out_ready never reaches in_ready.
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready && !flush;

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_xfer) begin
                    state_nxt = ST_ONE;
                    load_out  = 1'b1;
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_out = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: if (out_xfer) begin
                    state_nxt = ST_ONE;
                    pop_skid  = 1'b1;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm      <= '0;
            out_fmt      <= '0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else begin
            if (load_out) begin
                out_imm     <= dec.imm[XLEN-1:0];
                out_fmt     <= dec.fmt;
                out_illegal <= dec.illegal;
                out_tag     <= in_tag;
            end else if (pop_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm     <= dec.imm[XLEN-1:0];
                skid_fmt     <= dec.fmt;
                skid_illegal <= dec.illegal;
                skid_tag     <= in_tag;
            end
        end
    end

`ifdef IMM_GEN_STATS_EN
    // Counts accepted illegal opcodes only; a flush cycle never accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_count <= '0;
        else if (in_xfer && dec.illegal && !(&illegal_count))
            illegal_count <= illegal_count + CNT_W'(1);
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: queue model of the in-order buffer, per-cycle compare
// of an XLEN=32 and an XLEN=64 (CNT_W=2) instance, plus literal pins.
module tb_imm_gen_pipe;

    localparam int TW = 5;

    typedef struct {
        logic [63:0]   imm;
        logic [2:0]    fmt;
        logic          ill;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0]   in_instr = '0;
    logic [TW-1:0] in_tag = '0;

    logic v32, r32, ill32, v64, r64, ill64;
    logic [31:0]   imm32;
    logic [63:0]   imm64;
    logic [2:0]    fmt32, fmt64;
    logic [TW-1:0] tag32, tag64;
`ifdef IMM_GEN_STATS_EN
    logic [15:0] cnt32;
    logic [1:0]  cnt64;
`endif

    int n_vec = 0;
    int n_err = 0;
    exp_t q[$];
    exp_t e;
    int m_cnt32 = 0;
    int m_cnt64 = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TW), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
`ifdef IMM_GEN_STATS_EN
        , .illegal_count(cnt32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TW), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
`ifdef IMM_GEN_STATS_EN
        , .illegal_count(cnt64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate value as the signed integer each format encodes.
    function automatic exp_t model(input logic [31:0] i, input logic [TW-1:0] tag);
        exp_t r;
        r.tag = tag;
        r.ill = 1'b0;
        r.imm = 64'd0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin r.fmt = 3'd1; r.imm = 64'(longint'($signed(i[31:20]))); end
            7'h23: begin r.fmt = 3'd2; r.imm = 64'(longint'($signed({i[31:25], i[11:7]}))); end
            7'h63: begin r.fmt = 3'd3; r.imm = 64'(longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2); end
            7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = 64'(longint'($signed(i & 32'hFFFF_F000))); end
            7'h6F: begin r.fmt = 3'd5; r.imm = 64'(longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2); end
            7'h33: r.fmt = 3'd0;
            default: begin r.fmt = 3'd7; r.ill = 1'b1; end
        endcase
        return r;
    endfunction

    // Reference: an in-order queue of at most two results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cnt32 = 0;
            m_cnt64 = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            int sz;
            exp_t n;
            sz = q.size();
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz < 2) begin
                n = model(in_instr, in_tag);
                q.push_back(n);
                if (n.ill) begin
                    if (m_cnt32 < 65535) m_cnt32++;
                    if (m_cnt64 < 3) m_cnt64++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid32", 64'(v32), 64'(q.size() > 0));
        chk("in_ready32",  64'(r32), 64'(q.size() < 2));
        chk("out_valid64", 64'(v64), 64'(q.size() > 0));
        chk("in_ready64",  64'(r64), 64'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            chk("imm32", 64'(imm32), {32'd0, e.imm[31:0]});
            chk("imm64", imm64, e.imm);
            chk("fmt32", 64'(fmt32), 64'(e.fmt));
            chk("fmt64", 64'(fmt64), 64'(e.fmt));
            chk("ill32", 64'(ill32), 64'(e.ill));
            chk("tag32", 64'(tag32), 64'(e.tag));
            chk("tag64", 64'(tag64), 64'(e.tag));
        end
`ifdef IMM_GEN_STATS_EN
        chk("cnt32", 64'(cnt32), 64'(m_cnt32));
        chk("cnt64", 64'(cnt64), 64'(m_cnt64));
`endif
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [TW-1:0] tg,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] vecs [0:9];
    exp_t pin;

    initial begin
        vecs[0] = 32'h00C0006F; vecs[1] = 32'h002081B3; vecs[2] = 32'h07B00093;
        vecs[3] = 32'h12345097; vecs[4] = 32'hFF9FF0EF; vecs[5] = 32'h00209463;
        vecs[6] = 32'h80010103; vecs[7] = 32'h7FF12023; vecs[8] = 32'h0000000B;
        vecs[9] = 32'hFFC08067;

        // Model pins
        pin = model(32'hFFF00093, 0); chk("pin_addi", pin.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        pin = model(32'hFE112E23, 0); chk("pin_sw",   pin.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        pin = model(32'hFE000CE3, 0); chk("pin_beq",  pin.imm, 64'hFFFF_FFFF_FFFF_FFF8);
        pin = model(32'h800000B7, 0); chk("pin_lui",  pin.imm, 64'hFFFF_FFFF_8000_0000);
        pin = model(32'h00C0006F, 0); chk("pin_jal",  pin.imm, 64'd12);
        pin = model(32'h0000007F, 0); chk("pin_bad",  64'(pin.fmt), 64'd7);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 64'(v32), 64'd0);
        chk("rst_ready", 64'(r32), 64'd1);
        chk("rst_imm",   64'(imm64), 64'd0);
        chk("rst_fmt",   64'(fmt32), 64'd0);
        chk("rst_ill",   64'(ill32), 64'd0);
        chk("rst_tag",   64'(tag32), 64'd0);
        rst = 1'b0;
        step(0, 0, 0, 1, 0);

        step(1, 32'hFFF00093, 1, 1, 0);
        chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(fmt32), 64'd1);
        chk("addi_vld", 64'(v32), 64'd1);
        step(1, 32'hFE112E23, 2, 1, 0);
        chk("sw_imm", 64'(imm32), 64'hFFFF_FFFC);
        chk("sw_fmt", 64'(fmt32), 64'd2);
        step(1, 32'hFE000CE3, 3, 1, 0);
        chk("beq_imm", 64'(imm32), 64'hFFFF_FFF8);
        chk("beq_fmt", 64'(fmt32), 64'd3);
        step(1, 32'h800000B7, 4, 1, 0);
        chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_fmt",   64'(fmt64), 64'd4);
        step(1, 32'h0000007F, 5, 1, 0);
        chk("bad_ill", 64'(ill32), 64'd1);
        chk("bad_imm", 64'(imm32), 64'd0);
        chk("bad_fmt", 64'(fmt32), 64'd7);
`ifdef IMM_GEN_STATS_EN
        chk("bad_cnt", 64'(cnt32), 64'd1);
`endif
        step(0, 0, 0, 1, 0);

        // Backpressure: 1,2 accepted, 3 held, then drained in order
        step(1, 32'h00100093, 1, 0, 0);
        step(1, 32'h00200093, 2, 0, 0);
        chk("bp_ready", 64'(r32), 64'd0);
        step(1, 32'h00300093, 3, 0, 0);
        chk("bp_tag1", 64'(tag32), 64'd1);
        chk("bp_ready2", 64'(r32), 64'd0);
        step(1, 32'h00300093, 3, 1, 0);
        chk("bp_tag2", 64'(tag32), 64'd2);
        step(1, 32'h00300093, 3, 1, 0);
        chk("bp_tag3", 64'(tag32), 64'd3);
        step(0, 0, 0, 1, 0);
        chk("bp_empty", 64'(v32), 64'd0);

        // Flush from full, with an illegal opcode offered in the same cycle
        step(1, 32'h00100093, 6, 0, 0);
        step(1, 32'h00200093, 7, 0, 0);
        step(1, 32'h0000007F, 8, 0, 1);
        chk("fl_valid", 64'(v32), 64'd0);
        chk("fl_ready", 64'(r32), 64'd1);
        step(0, 0, 0, 1, 0);
        chk("fl_nothing", 64'(v32), 64'd0);

        // Reset asserted mid-cycle with two entries held
        step(1, 32'h00100093, 9, 0, 0);
        step(1, 32'h0000007F, 10, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(v32), 64'd0);
        chk("mid_rst_tag",   64'(tag32), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(0, 0, 0, 1, 0);

        // Counter saturation on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) step(1, 32'h0000007F, TW'(k), 1, 0);
`ifdef IMM_GEN_STATS_EN
        chk("sat_cnt64", 64'(cnt64), 64'd3);
        chk("sat_cnt32", 64'(cnt32), 64'd5);
`endif
        step(0, 0, 0, 1, 0);

        // Mixed traffic with intermittent valid and ready
        for (int k = 0; k < 40; k++)
            step((k % 3) != 2, vecs[k % 10], TW'(k), (k % 4) != 1, 1'b0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
